// File: rtl/if_fetch.sv
// if_fetch: PC owner, BRAM fetch issue and small instruction FIFO.
// Optional IF_MISALIGN_CHK_EN adds a registered misaligned-jump pulse.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_data_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o,
  input  logic        inst_ready_i
`ifdef IF_MISALIGN_CHK_EN
  ,
  output logic        misalign_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   pc;
  logic          inflight;
  logic [31:0]   inflight_addr;
  logic [31:0]   mem_addr [DEPTH];
  logic [31:0]   mem_inst [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;

  logic          pop;
  logic          issue;
  logic          capture;
  logic [CW:0]   occ;

  // handshake, issue gating and capture decisions
  always_comb begin
    inst_valid_o = (count != '0) & ~jump_en_i;
    pop          = inst_valid_o & inst_ready_i;
    capture      = inflight & ~jump_en_i;
    occ          = {1'b0, count}
                 + (CW+1)'(inflight)
                 - (CW+1)'(pop);
    issue        = ~jump_en_i
                 & (occ < (CW+1)'(DEPTH));
  end

  assign rom_addr_o  = pc;
  assign inst_o      = mem_inst[rptr];
  assign inst_addr_o = mem_addr[rptr];

  // PC and in-flight tracking; a jump overrides any issue
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc            <= RESET_PC;
      inflight      <= 1'b0;
      inflight_addr <= '0;
    end else if (jump_en_i) begin
      pc            <= {jump_addr_i[31:2], 2'b00};
      inflight      <= 1'b0;
    end else if (issue) begin
      pc            <= pc + 32'd4;
      inflight      <= 1'b1;
      inflight_addr <= pc;
    end else begin
      inflight      <= 1'b0;
    end
  end

  // FIFO pointers and occupancy; a jump flushes everything
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (jump_en_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (capture) wptr <= wptr + AW'(1);
      if (pop)     rptr <= rptr + AW'(1);
      count <= count
             + CW'(capture)
             - CW'(pop);
    end
  end

  // FIFO storage: returned word tagged with its fetch address
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_addr[i] <= '0;
        mem_inst[i] <= '0;
      end
    end else if (capture) begin
      mem_addr[wptr] <= inflight_addr;
      mem_inst[wptr] <= rom_data_i;
    end
  end

`ifdef IF_MISALIGN_CHK_EN
  // one-cycle flag after a jump to a non word-aligned target
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) misalign_o <= 1'b0;
    else      misalign_o <= jump_en_i
                          & (|jump_addr_i[1:0]);
  end
`else
  logic unused_lo;
  assign unused_lo = ^jump_addr_i[1:0];
`endif

endmodule
